// File: rtl/carfield_domain_pwr_seq.sv
// carfield_domain_pwr_seq
//
// Clock/reset/isolation sequencer for the Carfield clock domains. Each domain
// has a clock enable, an active-low reset and an isolation enable. Power-on and
// power-off follow a fixed order, with cycle counts you can set per request.
// After reset, a boot scan powers up the domains in DefaultOnMask, lowest
// index first.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_valid_i       request valid; held by the requester until accepted
//   req_ready_o       high only when idle
//   req_idx_i         target domain
//   req_on_i          1 = power on, 0 = power off
//   settle_cycles_i   clock-settle cycles S, latched on acceptance
//   hold_cycles_i     reset-hold cycles H, latched on acceptance
//   clk_en_o          per-domain clock enable
//   rst_no            per-domain reset, active low
//   iso_o             per-domain isolation, 1 = isolated
//   status_o          per-domain "fully on" (clk_en & rst_n & ~iso)
//   busy_o            sequencer not idle
//   done_o            one-cycle pulse when a request completes
//   done_idx_o        domain of the most recent done/err pulse
//   err_o             one-cycle pulse for an out-of-range request index
module carfield_domain_pwr_seq #(
    parameter int unsigned              NumDomains    = 4,
    parameter int unsigned              CntWidth      = 8,
    parameter logic [NumDomains-1:0]    DefaultOnMask = NumDomains'(1),
    parameter logic [CntWidth-1:0]      DefaultSettle = CntWidth'(8),
    parameter logic [CntWidth-1:0]      DefaultHold   = CntWidth'(4),
    parameter int unsigned              IdxWidth      = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [IdxWidth-1:0]   req_idx_i,
    input  logic                  req_on_i,
    input  logic [CntWidth-1:0]   settle_cycles_i,
    input  logic [CntWidth-1:0]   hold_cycles_i,
    output logic [NumDomains-1:0] clk_en_o,
    output logic [NumDomains-1:0] rst_no,
    output logic [NumDomains-1:0] iso_o,
    output logic [NumDomains-1:0] status_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IdxWidth-1:0]   done_idx_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        StScan,
        StIdle,
        StOnClk,
        StOnRst,
        StOffIso,
        StOffRst
    } state_e;

    state_e                state;
    logic [CntWidth-1:0]   cnt;
    logic [CntWidth-1:0]   hold;
    logic [IdxWidth-1:0]   cur_idx;
    logic [NumDomains-1:0] pending;
    logic                  boot;
    logic [NumDomains-1:0] clk_en;
    logic [NumDomains-1:0] dom_rst_n;
    logic [NumDomains-1:0] iso;
    logic                  done;
    logic                  err;
    logic [IdxWidth-1:0]   done_idx;

    logic [NumDomains-1:0] dom_on;
    logic [NumDomains-1:0] dom_off;
    logic                  req_invalid;
    logic                  req_redundant;
    logic [IdxWidth-1:0]   scan_idx;

    assign dom_on  = clk_en & dom_rst_n & ~iso;
    assign dom_off = ~clk_en & ~dom_rst_n & iso;

    assign req_invalid   = (32'(req_idx_i) >= NumDomains);
    // Only meaningful when the index is in range; qualified by req_invalid below.
    assign req_redundant = req_on_i ? dom_on[req_idx_i] : dom_off[req_idx_i];

    // Lowest set bit of the boot-pending mask.
    always_comb begin
        scan_idx = '0;
        for (int i = int'(NumDomains) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                scan_idx = IdxWidth'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= StScan;
            cnt       <= '0;
            hold      <= '0;
            cur_idx   <= '0;
            pending   <= DefaultOnMask;
            boot      <= 1'b0;
            clk_en    <= '0;
            dom_rst_n <= '0;
            iso       <= '1;
            done      <= 1'b0;
            err       <= 1'b0;
            done_idx  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StScan: begin
                    if (pending == '0) begin
                        state <= StIdle;
                    end else begin
                        pending[scan_idx] <= 1'b0;
                        cur_idx           <= scan_idx;
                        boot              <= 1'b1;
                        clk_en[scan_idx]  <= 1'b1;
                        cnt               <= DefaultSettle;
                        hold              <= DefaultHold;
                        state             <= StOnClk;
                    end
                end
                StIdle: begin
                    if (req_valid_i) begin
                        boot <= 1'b0;
                        if (req_invalid) begin
                            err      <= 1'b1;
                            done_idx <= req_idx_i;
                        end else if (req_redundant) begin
                            done     <= 1'b1;
                            done_idx <= req_idx_i;
                        end else begin
                            cur_idx <= req_idx_i;
                            hold    <= hold_cycles_i;
                            if (req_on_i) begin
                                clk_en[req_idx_i] <= 1'b1;
                                cnt               <= settle_cycles_i;
                                state             <= StOnClk;
                            end else begin
                                iso[req_idx_i] <= 1'b1;
                                state          <= StOffIso;
                            end
                        end
                    end
                end
                StOnClk: begin
                    if (cnt == '0) begin
                        dom_rst_n[cur_idx] <= 1'b1;
                        cnt                <= hold;
                        state              <= StOnRst;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                StOnRst: begin
                    if (cnt == '0) begin
                        iso[cur_idx] <= 1'b0;
                        // Boot power-ons go back to the scan and stay silent.
                        if (boot) begin
                            state <= StScan;
                        end else begin
                            done     <= 1'b1;
                            done_idx <= cur_idx;
                            state    <= StIdle;
                        end
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                StOffIso: begin
                    dom_rst_n[cur_idx] <= 1'b0;
                    cnt                <= hold;
                    state              <= StOffRst;
                end
                StOffRst: begin
                    if (cnt == '0) begin
                        clk_en[cur_idx] <= 1'b0;
                        done            <= 1'b1;
                        done_idx        <= cur_idx;
                        state           <= StIdle;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                default: begin
                    state <= StScan;
                end
            endcase
        end
    end

    assign req_ready_o = (state == StIdle);
    assign busy_o      = (state != StIdle);
    assign clk_en_o    = clk_en;
    assign rst_no      = dom_rst_n;
    assign iso_o       = iso;
    assign status_o    = dom_on;
    assign done_o      = done;
    assign err_o       = err;
    assign done_idx_o  = done_idx;

endmodule

// File: doc/carfield_domain_pwr_seq.md
# carfield_domain_pwr_seq

Parametrised clock/reset/isolation sequencer for the Carfield clock domains (host, periph, alt, secure, and any further domains). It generalises the fixed four-entry domain index set into a runtime-controllable block: it drives a clock enable, an active-low domain reset and an isolation enable per domain, and powers domains up or down in a fixed, cycle-counted order. A boot scan brings up a parameter-selected set of domains after reset. Software-facing control logic issues on/off requests through a valid/ready port.

## Interface
- NumDomains, 4: number of domains; index 0..3 map to Host/Periph/Alt/Secure.
- CntWidth, 8: width of the settle/hold counters.
- DefaultOnMask, 4'b0001: domains powered up by the boot scan; width NumDomains.
- DefaultSettle, 8: clock-settle cycles used by the boot scan.
- DefaultHold, 4: reset-hold cycles used by the boot scan.
- IdxWidth, max(1, $clog2(NumDomains)): derived; not to be overridden.
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_idx_i  in  IdxWidth  target domain.
- req_on_i  in  1  1 = power on, 0 = power off.
- settle_cycles_i  in  CntWidth  S; latched on acceptance.
- hold_cycles_i  in  CntWidth  H; latched on acceptance.
- clk_en_o  out  NumDomains  per-domain clock enable (registered).
- rst_no  out  NumDomains  per-domain reset, active low (registered).
- iso_o  out  NumDomains  per-domain isolation, 1 = isolated (registered).
- status_o  out  NumDomains  clk_en & rst_n & ~iso per domain.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse, sequence complete.
- done_idx_o  out  IdxWidth  domain of the last done/err; holds value.
- err_o  out  1  one-cycle pulse, request had req_idx_i >= NumDomains.

## Operation
- States: SCAN, IDLE, ON_CLK, ON_RST, OFF_ISO, OFF_RST. The reset state is SCAN.
- Reset values: clk_en_o=0, rst_no=0, iso_o=all 1, status_o=0, done_o=0, err_o=0, done_idx_o=0, boot-pending mask=DefaultOnMask.
- SCAN: if the pending mask is 0, go to IDLE. Otherwise select the lowest set index, clear its bit, and start a power-on with S=DefaultSettle and H=DefaultHold. Each boot power-on returns to SCAN, not IDLE.
- Acceptance: an edge with req_valid_i & req_ready_o. While busy, requests are not accepted; the requester holds valid.
- Power-on, acceptance edge E0: set clk_en[idx], cnt<=S, go to ON_CLK.
  - ON_CLK: cnt==0 -> set rst_n[idx], cnt<=H, go to ON_RST; else decrement cnt.
  - ON_RST: cnt==0 -> clear iso[idx], pulse done_o, go to IDLE; else decrement cnt.
- Power-off, edge E0: set iso[idx], go to OFF_ISO.
  - OFF_ISO: clear rst_n[idx], cnt<=H, go to OFF_RST.
  - OFF_RST: cnt==0 -> clear clk_en[idx], pulse done_o, go to IDLE; else decrement cnt.
- Redundant request (on to an already-on domain, or off to a domain with clk_en=0, rst_n=0, iso=1): accepted, outputs unchanged, done_o pulses on the next cycle, state stays IDLE.
- Invalid index: accepted, no output change, err_o pulses on the next cycle, done_o stays 0, done_idx_o=req_idx_i truncated to IdxWidth.
- A domain in a partial state (neither fully on nor fully off) is never left that way by this block; both sequences drive all three signals explicitly.
- Only the addressed domain's bits change; all other domains are untouched.

## Timing
- Power-on: clk_en rises at E0, rst_n rises at E0+S+1, iso falls and done_o rises at E0+S+H+2. req_ready_o is high in the cycle after that edge.
- Power-off: iso rises at E0, rst_n falls at E0+1, clk_en falls and done_o rises at E0+H+2.
- The counter does not wrap: S=H=0 gives the minimum latencies of 2 cycles (on) and 2 cycles (off).
- Boot: one SCAN cycle before each boot power-on and one final SCAN cycle before IDLE.
- Asynchronous reset mid-sequence: all outputs return to their reset values immediately; the boot scan restarts after release.
- done_o and err_o are never high together and never high for more than one cycle.

## Test plan
- Boot with DefaultOnMask=0001, DefaultSettle=2, DefaultHold=3 -> clk_en_o[0] at cycle 1, rst_no[0] at 4, iso_o[0] low at 8, then IDLE; status_o=0001; done_o stays 0 during boot.
- Power-on of domain 2 with S=0, H=0 -> clk_en at E0, rst_n at E0+1, iso low and done_o=1 at E0+2 with done_idx_o=2; status_o=0101.
- Power-off of domain 0 with H=5 -> iso at E0, rst_no[0]=0 at E0+1, clk_en_o[0]=0 at E0+7; status_o=0100.
- Request held valid while busy -> not accepted until req_ready_o; queued off-request to domain 2 then completes; no other domain bit toggles.
- Redundant on to domain 2, then idx=5 with NumDomains=6 and then idx=7 -> first: done_o next cycle, no output change; idx 7: err_o=1 next cycle, done_o=0.
- rst_ni low at E0+1 of a power-on with S=10 -> outputs are immediately at reset values; after release the boot sequence repeats exactly as in scenario 1.
